// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter among N byte requesters
//
// Purpose: grants one requester at a time, latches its byte, fires a one-cycle
// start strobe at the transmitter, waits for end-of-frame, then holds the line
// idle for GAP_TICKS oversample ticks before the next grant.
//
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN
//   defined   -> 24-bit watchdog in WAIT; expiry pulses err and moves to GAP
//   undefined -> WAIT exits only on tx_done; err tied low
//
// Ports:
//   clk         system clock
//   rstN        asynchronous, active-high reset
//   req_valid   per-requester byte pending
//   req_data    requester i byte at [8*i+7:8*i]
//   req_ready   one-hot accept, combinational, only ever set in IDLE
//   s_tick      oversample tick from the baud generator
//   tx_done     end-of-frame pulse from the transmitter
//   tx_enabled  one-cycle start strobe to the transmitter
//   tx_in       byte to the transmitter, held until the next strobe
//   busy        high in every state except IDLE
//   grant_id    index of the last granted requester
//   err         one-cycle pulse on watchdog abort

module uart_tx_scheduler #(
    parameter int N              = 4,
    parameter int IDW            = $clog2(N),
    parameter int GAP_TICKS      = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    input  logic             s_tick,
    input  logic             tx_done,
    output logic             tx_enabled,
    output logic [7:0]       tx_in,
    output logic             busy,
    output logic [IDW-1:0]   grant_id,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    state_t           state_q, state_d;
    logic [7:0]       tx_in_q, tx_in_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [7:0]       gap_q, gap_d;

    // Unpacked view of the byte lanes so the grant index selects a lane directly.
    logic [7:0]       lanes [N];
    for (genvar g = 0; g < N; g++) begin : g_lanes
        assign lanes[g] = req_data[8*g+7:8*g];
    end

    // Round-robin search starting just past the last winner, so the winner
    // drops to lowest priority on the following round.
    logic             found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   idx;
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(last_q) + i) % N);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE && found) ? (N'(1) << pick_idx) : '0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] wdog_q, wdog_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        tx_in_d = tx_in_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    tx_in_d = lanes[pick_idx];
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A tick coinciding with tx_done is not part of the gap: the
                // gap counter starts from zero in the first GAP cycle.
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
                end else begin
                    wdog_d  = wdog_q + 24'd1;
                end
`endif
            end
            S_GAP: begin
                if (s_tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            state_q <= S_IDLE;
            tx_in_q <= 8'h00;
            grant_q <= '0;
            last_q  <= IDW'(N - 1);
            gap_q   <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_in_q <= tx_in_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign tx_enabled = (state_q == S_LAUNCH);
    assign tx_in      = tx_in_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler

module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        s_tick = 1'b0;
    logic        tx_done = 1'b0;

    logic [3:0]  req_ready, req_ready0;
    logic        tx_enabled, tx_enabled0;
    logic [7:0]  tx_in, tx_in0;
    logic        busy, busy0;
    logic [1:0]  grant_id, grant_id0;
    logic        err, err0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N(4), .GAP_TICKS(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .s_tick(s_tick), .tx_done(tx_done),
        .tx_enabled(tx_enabled), .tx_in(tx_in), .busy(busy),
        .grant_id(grant_id), .err(err)
    );

    uart_tx_scheduler #(.N(4), .GAP_TICKS(0), .TIMEOUT_CYCLES(100)) dut0 (
        .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready0), .s_tick(s_tick), .tx_done(tx_done),
        .tx_enabled(tx_enabled0), .tx_in(tx_in0), .busy(busy0),
        .grant_id(grant_id0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the strobe, checks it against the scoreboard head,
    // then steps into WAIT and confirms the strobe lasted one cycle.
    task automatic wait_strobe();
        int   c;
        exp_t e;
        c = 0;
        while (tx_enabled !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk("strobe_seen", tx_enabled, 1);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tx_in", tx_in, e.b);
            chk("grant_id", grant_id, e.id);
        end
        chk("busy_launch", busy, 1);
        tick();
        chk("strobe_one_cycle", tx_enabled, 0);
    endtask

    task automatic send_done(input logic with_tick);
        tx_done = 1'b1;
        s_tick  = with_tick;
        tick();
        tx_done = 1'b0;
        s_tick  = 1'b0;
    endtask

    task automatic run_gap(input int period, input logic [3:0] mask);
        for (int i = 0; i < 16; i++) begin
            repeat (period - 1) tick();
            s_tick = 1'b1;
            #1;
            chk("gap_busy", busy, 1);
            chk("gap_ready", req_ready, 0);
            tick();
            s_tick = 1'b0;
        end
        chk("gap_end_busy", busy, 0);
        chk("gap_end_ready", req_ready, mask);
    endtask

    task automatic pulse_reset();
        #2 rstN = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tx_in", tx_in, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_strobe", tx_enabled, 0);
        chk("rst_err", err, 0);
        tick();
        rstN = 1'b0;
    endtask

    initial begin
        logic [3:0] m;
        int c;

        // Reset values while reset is held
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_tx_in", tx_in, 8'h00);
        chk("reset_grant", grant_id, 0);
        chk("reset_strobe", tx_enabled, 0);
        chk("reset_err", err, 0);
        rstN = 1'b0;
        tick();

        // Single requester 2, then requester 1 waiting through the gap
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        push(2'd2, 8'hA5);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        repeat (5) tick();
        chk("wait_busy", busy, 1);
        chk("tx_in_hold", tx_in, 8'hA5);
        send_done(1'b1);
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        run_gap(4, 4'b0010);
        push(2'd1, 8'h5A);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        send_done(1'b0);
        run_gap(1, 4'b0000);

        // All valid, 8 frames: strict rotation starting at 0
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            for (int j = 0; j < 4; j++) req_data[8*j +: 8] = 8'(8'h10 + f);
            #1;
            m = 4'(1 << (f % 4));
            chk("rr_ready", req_ready, m);
            push(2'(f % 4), 8'(8'h10 + f));
            tick();
            wait_strobe();
            repeat (2) tick();
            send_done(1'b0);
            run_gap(1, 4'(1 << ((f + 1) % 4)));
        end
        req_valid = 4'b0000;

        // GAP_TICKS = 0: next handshake the cycle after tx_done
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
        req_data[7:0]  = 8'h21;
        req_data[15:8] = 8'h22;
        req_valid = 4'b0011;
        #1;
        chk("g0_ready_a", req_ready0, 4'b0001);
        push(2'd0, 8'h21);
        tick();
        req_valid = 4'b0010;
        chk("g0_strobe_a", tx_enabled0, 1);
        wait_strobe();
        repeat (3) tick();
        send_done(1'b0);
        chk("g0_idle", busy0, 0);
        chk("g0_ready_b", req_ready0, 4'b0010);
        chk("g16_busy", busy, 1);
        tick();
        chk("g0_strobe_b", tx_enabled0, 1);
        chk("g0_grant_b", grant_id0, 1);
        chk("g0_tx_in_b", tx_in0, 8'h22);
        req_valid = 4'b0000;
        run_gap(1, 4'b0000);

        // Withdrawn request in IDLE: ready moves to the remaining requester
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
        req_data[7:0]  = 8'h31;
        req_data[15:8] = 8'h32;
        req_valid = 4'b0011;
        #1;
        chk("wd_ready_a", req_ready, 4'b0001);
        req_valid = 4'b0010;
        #1;
        chk("wd_ready_b", req_ready, 4'b0010);
        push(2'd1, 8'h32);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        send_done(1'b0);
        run_gap(1, 4'b0000);
        repeat (3) tick();
        chk("wd_no_strobe", tx_enabled, 0);

        // Reset during WAIT, then during GAP; requester 0 wins afterwards
        req_data[23:16] = 8'h44;
        req_valid = 4'b0100;
        #1;
        push(2'd2, 8'h44);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        repeat (3) tick();
        pulse_reset();
        for (int j = 0; j < 4; j++) req_data[8*j +: 8] = 8'h50;
        req_valid = 4'b1111;
        #1;
        chk("rst_wait_ready", req_ready, 4'b0001);
        push(2'd0, 8'h50);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        send_done(1'b0);
        repeat (3) tick();
        chk("gap_before_rst", busy, 1);
        pulse_reset();
        req_valid = 4'b1111;
        #1;
        chk("rst_gap_ready", req_ready, 4'b0001);
        push(2'd0, 8'h50);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        send_done(1'b0);
        run_gap(1, 4'b0000);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog expiry 100 cycles after WAIT entry, then gap, then next grant
        req_data[7:0] = 8'h61;
        req_valid = 4'b0001;
        #1;
        push(2'd1, 8'h61);
        exp_q[exp_q.size()-1].id = 2'd1;
        exp_q.delete(exp_q.size()-1);
        req_valid = 4'b0010;
        req_data[15:8] = 8'h61;
        #1;
        push(2'd1, 8'h61);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        c = 0;
        while (err !== 1'b1 && c < 150) begin
            tick();
            c++;
        end
        chk("timeout_latency", c, 100);
        chk("timeout_busy", busy, 1);
        tick();
        chk("err_one_cycle", err, 0);
        req_data[23:16] = 8'h62;
        req_valid = 4'b0100;
        run_gap(1, 4'b0100);
        push(2'd2, 8'h62);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        repeat (99) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("done_at_expiry_err", err, 0);
        chk("done_at_expiry_gap", busy, 1);
        tick();
        chk("done_at_expiry_err2", err, 0);
        run_gap(1, 4'b0000);
`else
        // Without the watchdog WAIT holds indefinitely and err stays low
        req_data[7:0] = 8'h61;
        req_valid = 4'b0001;
        #1;
        push(2'd0, 8'h61);
        tick();
        req_valid = 4'b0000;
        wait_strobe();
        repeat (150) tick();
        chk("no_wdog_busy", busy, 1);
        chk("no_wdog_err", err, 0);
        send_done(1'b0);
        run_gap(1, 4'b0000);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
